reg_bus_arbiter: RTL and testbench

//   Shares the single-port safety register file between two masters: port A (I2C slave

---
 rtl/reg_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-master round-robin arbiter for the safety register file
// One access in flight, fixed read latency, and refused writes into the locked limit window.
module reg_bus_arbiter #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 8,
    parameter int                RD_LAT  = 1,
    parameter logic [ADDR_W-1:0] LOCK_LO = '0,
    parameter logic [ADDR_W-1:0] LOCK_HI = ADDR_W'(8'h19)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              lock,
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              last_gnt,
    output logic [7:0]        reject_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    state_t            state;
    logic [1:0]        wait_cnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              pick_b;
    logic              in_window;
    logic              refuse_now;
    logic              finish;

    // last_gnt doubles as the current grant once an access has been captured
    assign pick_b     = b_req && (!a_req || !last_gnt);
    // extra MSB keeps the lower-bound compare well-formed when LOCK_LO is zero
    assign in_window  = ({1'b1, cap_addr} >= {1'b1, LOCK_LO}) && (cap_addr <= LOCK_HI);
    assign refuse_now = (state == ISSUE) && cap_we && lock && in_window;
    assign finish     = ((state == ISSUE) && (refuse_now || RD_LAT == 0))
                     || ((state == WAIT) && (wait_cnt == WAIT_LAST));

    assign bus_en    = (state == ISSUE) && !refuse_now;
    assign bus_we    = cap_we;
    assign bus_addr  = cap_addr;
    assign bus_wdata = cap_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            last_gnt   <= 1'b1;
            a_ack      <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            reject_cnt <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        last_gnt  <= pick_b;
                        cap_we    <= pick_b ? b_we    : a_we;
                        cap_addr  <= pick_b ? b_addr  : a_addr;
                        cap_wdata <= pick_b ? b_wdata : a_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= finish ? RESP : WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (finish) state <= RESP;
                end
                default: state <= IDLE;
            endcase

            // response registers load on the edge into RESP so they are valid there
            if (finish) begin
                if (last_gnt) begin
                    b_ack <= 1'b1;
                    b_err <= refuse_now;
                    if (!cap_we) b_rdata <= bus_rdata;
                end else begin
                    a_ack <= 1'b1;
                    a_err <= refuse_now;
                    if (!cap_we) a_rdata <= bus_rdata;
                end
                if (refuse_now && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed self-checking bench for reg_bus_arbiter
// Register file is a read-only pattern ROM with one cycle of read latency.
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, lock = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00, b_addr = 8'h00, b_wdata = 8'h00;
    logic       a_ack, a_err, b_ack, b_err, bus_en, bus_we, busy, last_gnt;
    logic [7:0] a_rdata, b_rdata, bus_addr, bus_wdata, reject_cnt;
    logic [7:0] bus_rdata = 8'h00;

    int checks = 0;
    int failures = 0;

    // results of the most recent access() call
    logic       saw_en, en_we, got_ack, got_err, saw_other;
    logic [7:0] en_addr, en_wdata, got_rdata;
    int         lat;
    logic       who;
    logic       found;

    reg_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .lock(lock), .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy), .last_gnt(last_gnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [7:0] addr);
        return (addr == 8'h1A) ? 8'h5C : (addr ^ 8'h3C);
    endfunction

    always @(posedge clk) if (bus_en) bus_rdata <= rom(bus_addr);

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Starts in IDLE at a negedge; returns in IDLE at a negedge with req dropped.
    task automatic access(input logic port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata);
        saw_en = 0; en_we = 0; en_addr = 0; en_wdata = 0;
        got_ack = 0; got_err = 0; got_rdata = 0; saw_other = 0; lat = 0;
        if (port) begin b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
        else      begin a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
        for (int i = 0; i < 12 && !got_ack; i++) begin
            step();
            lat++;
            if (bus_en) begin saw_en = 1; en_we = bus_we; en_addr = bus_addr; en_wdata = bus_wdata; end
            if ((port ? a_ack : b_ack)) saw_other = 1;
            if ((port ? b_ack : a_ack)) begin
                got_ack = 1;
                got_err = port ? b_err : a_err;
                got_rdata = port ? b_rdata : a_rdata;
            end
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
        if (!got_ack) check("access_timeout", 0, 1);
        step();
    endtask

    initial begin
        // reset state
        step();
        check("rst_busy", busy, 0);
        check("rst_bus_en", bus_en, 0);
        check("rst_last_gnt", last_gnt, 1);
        check("rst_reject", reject_cnt, 0);
        check("rst_acks", {a_ack, b_ack, a_err, b_err}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        rst = 1'b1;
        step();

        // 1: single A read, bus_en at T+1, ack at T+3
        a_we = 0; a_addr = 8'h1A; a_req = 1;
        step();
        check("t1_en", bus_en, 1);
        check("t1_addr", {bus_we, bus_addr}, {1'b0, 8'h1A});
        step();
        check("t1_wait_en", {bus_en, a_ack}, 0);
        step();
        check("t1_ack", {a_ack, b_ack, a_err}, 3'b100);
        check("t1_rdata", a_rdata, 8'h5C);
        check("t1_gnt", last_gnt, 0);
        a_req = 0;
        step();
        check("t1_idle", {busy, a_ack}, 0);

        // 2: simultaneous requests from reset, A first, B at T+5/T+7
        do_reset();
        a_we = 0; a_addr = 8'h10; b_we = 0; b_addr = 8'h30;
        a_req = 1; b_req = 1;
        step();
        check("t2_a_en", {bus_en, bus_addr}, {1'b1, 8'h10});
        step(); step();
        check("t2_a_ack", {a_ack, b_ack}, 2'b10);
        check("t2_a_rdata", a_rdata, 8'h2C);
        a_req = 0;
        step();
        check("t2_idle_gap", {busy, bus_en}, 0);
        step();
        check("t2_b_en", {bus_en, bus_addr}, {1'b1, 8'h30});
        step(); step();
        check("t2_b_ack", {a_ack, b_ack}, 2'b01);
        check("t2_b_rdata", b_rdata, 8'h0C);
        check("t2_gnt", last_gnt, 1);
        b_req = 0;
        step();

        // 3: B holds req, A re-requests; strict alternation starting with A
        a_addr = 8'h05; b_addr = 8'h06; a_req = 1; b_req = 1;
        for (int i = 0; i < 8; i++) begin
            found = 0; who = 0;
            for (int k = 0; k < 10 && !found; k++) begin
                step();
                if (a_ack || b_ack) begin found = 1; who = b_ack; end
            end
            check($sformatf("t3_order%0d", i), {found, who}, {1'b1, 1'(i % 2)});
            if (!who) begin a_req = 0; step(); a_req = 1; end
            else begin
                step();
                if (i == 7) begin a_req = 0; b_req = 0; end
            end
        end
        step();
        check("t3_quiet", busy, 0);

        // 4: lock window
        lock = 1;
        access(0, 1, 8'h04, 8'hFF);
        check("t4_ref_en", saw_en, 0);
        check("t4_ref_err", {got_ack, got_err}, 2'b11);
        check("t4_ref_lat", lat, 2);
        check("t4_ref_cnt", reject_cnt, 1);
        access(0, 1, 8'h19, 8'h11);
        check("t4_hi_err", {saw_en, got_err}, 2'b01);
        access(0, 1, 8'h1A, 8'h22);
        check("t4_above_err", {saw_en, got_err}, 2'b10);
        access(0, 1, 8'h20, 8'h01);
        check("t4_wr_bus", {saw_en, en_we, en_addr, en_wdata}, {2'b11, 8'h20, 8'h01});
        check("t4_wr_err", got_err, 0);
        check("t4_wr_lat", lat, 3);
        access(0, 0, 8'h04, 8'h00);
        check("t4_rd", {saw_en, en_we, got_err}, 3'b100);
        check("t4_rd_data", got_rdata, 8'h38);
        access(1, 1, 8'h00, 8'h33);
        check("t4_b_ref", {saw_en, got_err, saw_other}, 3'b010);
        check("t4_cnt", reject_cnt, 3);
        lock = 0;
        access(0, 1, 8'h04, 8'h44);
        check("t4_unlock", {saw_en, got_err, reject_cnt}, {2'b10, 8'd3});

        // 5: saturation
        do_reset();
        check("t5_cleared", reject_cnt, 0);
        lock = 1;
        for (int i = 0; i < 254; i++) access(0, 1, 8'h08, 8'h00);
        check("t5_254", reject_cnt, 8'hFE);
        access(0, 1, 8'h08, 8'h00);
        check("t5_255", reject_cnt, 8'hFF);
        for (int i = 0; i < 45; i++) access(1, 1, 8'h09, 8'h00);
        check("t5_300", reject_cnt, 8'hFF);
        lock = 0;

        // 6: reset in WAIT aborts; pending B served afterwards
        do_reset();
        a_we = 0; a_addr = 8'h1A; a_req = 1;
        step();
        step();
        check("t6_in_wait", {busy, bus_en}, 2'b10);
        b_we = 0; b_addr = 8'h30; b_req = 1;
        rst = 0;
        #1;
        check("t6_abort", {busy, bus_en, a_ack, b_ack, a_err, b_err}, 0);
        check("t6_abort_regs", {last_gnt, reject_cnt, a_rdata}, {1'b1, 16'h0000});
        a_req = 0;
        step();
        check("t6_no_ack", {a_ack, bus_en, a_rdata}, 0);
        rst = 1;
        found = 0; lat = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            lat++;
            check($sformatf("t6_no_a_ack%0d", k), a_ack, 0);
            if (b_ack) found = 1;
        end
        check("t6_b_served", {found, b_rdata, a_rdata}, {1'b1, 8'h0C, 8'h00});
        check("t6_b_lat", lat, 3);
        b_req = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
